// File: rtl/instr_fetch_buffer_pkg.sv
// Shared widths, the NOP encoding and the fetch entry layout for the
// instruction fetch buffer.
package instr_fetch_buffer_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int INSTR_W_DEF = 32;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instr_fetch_buffer_if.sv
// PC, instruction-memory and decode signals of the fetch buffer. The slave
// modport is the buffer's view; master is the surrounding pipeline's view.
interface instr_fetch_buffer_if
  import instr_fetch_buffer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);

  logic [ADDR_W-1:0]           pc_in;
  logic                        pc_valid;
  logic                        redirect;
  logic                        fetch_stall;
  logic                        imem_rd_en;
  logic [ADDR_W-1:0]           imem_addr;
  logic [INSTR_W-1:0]          imem_rdata;
  logic                        dec_valid;
  logic                        dec_ready;
  logic [INSTR_W-1:0]          dec_instr;
  logic [ADDR_W-1:0]           dec_pc;
  logic [occ_width(DEPTH)-1:0] occupancy;

  modport slave (
    input  pc_in, pc_valid, redirect, imem_rdata, dec_ready,
    output fetch_stall, imem_rd_en, imem_addr, dec_valid, dec_instr, dec_pc, occupancy
  );

  modport master (
    output pc_in, pc_valid, redirect, imem_rdata, dec_ready,
    input  fetch_stall, imem_rd_en, imem_addr, dec_valid, dec_instr, dec_pc, occupancy
  );

endinterface

// File: rtl/instr_fetch_buffer_sync_fifo.sv
// Power-of-two synchronous FIFO with a combinational head read and a flush
// that discards every entry and takes priority over push and pop.
module instr_fetch_buffer_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push & ~i_flush;
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (PTR_W+1)'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - (PTR_W+1)'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; the count and pointers
  // decide validity, and leaving it unreset lets it map onto plain RAM/regfile.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);

  // The fetch credit scheme must never let a response arrive with no room.
  a_no_push_when_full : assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && o_full));

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch buffer: issues one imem read per cycle under registered credit, tags
// responses with their PC, queues them and presents them to decode.
module instr_fetch_buffer
  import instr_fetch_buffer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_fetch_buffer_if.slave  bus
);

  localparam int CNT_W   = occ_width(DEPTH);
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  logic               r_inflight;
  logic               r_squash;
  logic [ADDR_W-1:0]  r_tag;

  logic               w_space;
  logic [CNT_W:0]     w_credit_used;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_count;
  logic [ENTRY_W-1:0] w_din;
  logic [ENTRY_W-1:0] w_dout;

  // Credit counts only registered state, so a pop never frees a slot in the
  // same cycle and dec_ready has no combinational path to fetch_stall.
  assign w_credit_used = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_space       = (w_credit_used < (CNT_W+1)'(DEPTH));
  assign w_issue       = bus.pc_valid & w_space & ~bus.redirect & ~rst;

  assign bus.fetch_stall = bus.pc_valid & ~w_space;
  assign bus.imem_rd_en  = w_issue;
  assign bus.imem_addr   = bus.pc_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_squash   <= 1'b0;
      r_tag      <= '0;
    end else begin
      r_inflight <= w_issue;
      r_squash   <= bus.redirect & r_inflight;
      if (w_issue) r_tag <= bus.pc_in;
    end
  end

  assign w_push = r_inflight & ~r_squash;
  assign w_din  = {r_tag, bus.imem_rdata};
  assign w_pop  = ~w_empty & bus.dec_ready;

  instr_fetch_buffer_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirect),
    .i_din   (w_din),
    .o_dout  (w_dout),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Head is masked when empty so decode sees a clean NOP/zero PC.
  assign bus.dec_valid = ~w_empty;
  assign bus.dec_pc    = w_empty ? '0 : w_dout[ENTRY_W-1 -: ADDR_W];
  assign bus.dec_instr = w_empty ? INSTR_W'(NOP_INSTR) : w_dout[INSTR_W-1:0];
  assign bus.occupancy = w_count;

  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer: reset, streaming, back-pressure,
// redirect squash, pointer wrap and mid-stream reset.
module tb_instr_fetch_buffer;
  import instr_fetch_buffer_pkg::*;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  logic [31:0] stream_max_occ;

  instr_fetch_buffer_if #(.DEPTH(4), .ADDR_W(32), .INSTR_W(32)) ifc ();

  instr_fetch_buffer #(.DEPTH(4), .ADDR_W(32), .INSTR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: 1-cycle latency, word at address a holds 0xA0 + a.
  always @(posedge clk) begin
    if (ifc.imem_rd_en) ifc.imem_rdata <= 32'hA0 + ifc.imem_addr;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives PCs pc_first..pc_last as credit allows and checks every pop
  // against the next expected PC starting at exp_first.
  task automatic stream(input logic [31:0] pc_first, input logic [31:0] pc_last,
                        input logic [31:0] exp_first, input bit toggle, input int budget);
    logic [31:0] pc;
    logic [31:0] exp;
    int          n;
    pc = pc_first;
    exp = exp_first;
    n = 0;
    stream_max_occ = 0;
    while ((exp <= pc_last) && (n < budget)) begin
      cyc();
      ifc.pc_in     = pc;
      ifc.pc_valid  = (pc <= pc_last);
      ifc.dec_ready = toggle ? (n % 2 == 0) : 1'b1;
      #2;
      if (32'(ifc.occupancy) > stream_max_occ) stream_max_occ = 32'(ifc.occupancy);
      if (ifc.imem_rd_en) pc = pc + 1;
      if (ifc.dec_valid && ifc.dec_ready) begin
        check("stream_pc", 64'(ifc.dec_pc), 64'(exp));
        check("stream_instr", 64'(ifc.dec_instr), 64'(32'hA0 + exp));
        exp = exp + 1;
      end
      n++;
    end
    check("stream_all_popped", 64'(exp), 64'(pc_last + 1));
    ifc.pc_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pc;
    int          n_issue;
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    ifc.pc_in = '0;
    ifc.pc_valid = 1'b1;
    ifc.redirect = 1'b0;
    ifc.dec_ready = 1'b0;

    // Reset held two cycles with pc_valid asserted.
    cyc();
    cyc();
    #2;
    check("rst_rd_en", 64'(ifc.imem_rd_en), 64'd0);
    check("rst_dec_valid", 64'(ifc.dec_valid), 64'd0);
    check("rst_occupancy", 64'(ifc.occupancy), 64'd0);
    check("rst_fetch_stall", 64'(ifc.fetch_stall), 64'd0);
    check("rst_dec_pc", 64'(ifc.dec_pc), 64'd0);
    check("rst_dec_instr", 64'(ifc.dec_instr), 64'd0);

    // Streaming pc 0..3 with decode always ready.
    rst = 1'b0;
    ifc.pc_in = 32'd0;
    ifc.dec_ready = 1'b1;
    #1;
    check("str_issue0", 64'(ifc.imem_rd_en), 64'd1);
    check("str_addr0", 64'(ifc.imem_addr), 64'd0);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      ifc.pc_in = 32'(k);
      ifc.pc_valid = (k <= 3);
      #2;
      check("str_dec_valid", 64'(ifc.dec_valid), 64'(k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) begin
        check("str_dec_pc", 64'(ifc.dec_pc), 64'(k - 2));
        check("str_dec_instr", 64'(ifc.dec_instr), 64'(32'hA0 + 32'(k - 2)));
      end
      check("str_occ_le1", 64'(ifc.occupancy <= 1), 64'd1);
    end

    // Back-pressure: decode stalled, exactly DEPTH issues then fetch_stall.
    pc = 0;
    n_issue = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      ifc.pc_in = pc;
      ifc.pc_valid = 1'b1;
      ifc.dec_ready = 1'b0;
      #2;
      if (ifc.imem_rd_en) begin
        pc = pc + 1;
        n_issue++;
      end
    end
    check("bp_issue_count", 64'(n_issue), 64'd4);
    check("bp_fetch_stall", 64'(ifc.fetch_stall), 64'd1);
    check("bp_occupancy", 64'(ifc.occupancy), 64'd4);
    check("bp_head_pc", 64'(ifc.dec_pc), 64'd0);
    check("bp_head_instr", 64'(ifc.dec_instr), 64'hA0);

    // Drain in order; issue resumes at pc 4.
    stream(32'd4, 32'd7, 32'd0, 1'b0, 40);
    cyc();
    #2;
    check("drain_empty", 64'(ifc.occupancy), 64'd0);

    // Redirect while pc 5 is in flight; target is pc 20.
    ifc.pc_in = 32'd5;
    ifc.pc_valid = 1'b1;
    ifc.dec_ready = 1'b1;
    #2;
    check("rd_issue5", 64'(ifc.imem_rd_en), 64'd1);
    cyc();
    ifc.pc_in = 32'd6;
    ifc.redirect = 1'b1;
    #2;
    check("rd_no_issue", 64'(ifc.imem_rd_en), 64'd0);
    cyc();
    ifc.redirect = 1'b0;
    ifc.pc_in = 32'd20;
    #2;
    check("rd_after_valid", 64'(ifc.dec_valid), 64'd0);
    check("rd_after_occ", 64'(ifc.occupancy), 64'd0);
    check("rd_issue20", 64'(ifc.imem_rd_en), 64'd1);
    cyc();
    ifc.pc_valid = 1'b0;
    #2;
    check("rd_no_pc5", 64'(ifc.dec_valid), 64'd0);
    cyc();
    #2;
    check("rd_tgt_valid", 64'(ifc.dec_valid), 64'd1);
    check("rd_tgt_pc", 64'(ifc.dec_pc), 64'd20);
    check("rd_tgt_instr", 64'(ifc.dec_instr), 64'hB4);
    cyc();
    #2;
    check("rd_final_empty", 64'(ifc.dec_valid), 64'd0);

    // Wrap with decode ready toggling 1/0.
    stream(32'd40, 32'd49, 32'd40, 1'b1, 80);
    check("wrap_max_occ", 64'(stream_max_occ <= 4), 64'd1);

    // Mid-stream reset with three queued and one in flight.
    pc = 60;
    for (int k = 0; k < 4; k++) begin
      cyc();
      ifc.pc_in = pc;
      ifc.pc_valid = 1'b1;
      ifc.dec_ready = 1'b0;
      #2;
      check("mr_issue", 64'(ifc.imem_rd_en), 64'd1);
      pc = pc + 1;
    end
    cyc();
    rst = 1'b1;
    ifc.pc_in = pc;
    #2;
    check("mr_occ_before", 64'(ifc.occupancy), 64'd3);
    check("mr_rst_no_issue", 64'(ifc.imem_rd_en), 64'd0);
    cyc();
    rst = 1'b0;
    ifc.pc_in = 32'd100;
    ifc.dec_ready = 1'b1;
    #2;
    check("mr_occ_after", 64'(ifc.occupancy), 64'd0);
    check("mr_valid_after", 64'(ifc.dec_valid), 64'd0);
    check("mr_issue100", 64'(ifc.imem_rd_en), 64'd1);
    cyc();
    ifc.pc_valid = 1'b0;
    #2;
    check("mr_no_stale", 64'(ifc.dec_valid), 64'd0);
    cyc();
    #2;
    check("mr_new_valid", 64'(ifc.dec_valid), 64'd1);
    check("mr_new_pc", 64'(ifc.dec_pc), 64'd100);
    check("mr_new_instr", 64'(ifc.dec_instr), 64'h104);
    cyc();
    #2;
    check("mr_final_empty", 64'(ifc.occupancy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
